// File: rtl/vga_pkg.sv
// Shared VGA geometry and framebuffer pixel/word types.
package vga_pkg;

    localparam int unsigned SIZE     = 3;
    localparam int unsigned H_PIXELS = 50 * SIZE;
    localparam int unsigned V_PIXELS = 25 * SIZE;
    localparam int unsigned H_BITS   = 8;
    localparam int unsigned V_BITS   = 7;
    localparam int unsigned PIX_W    = 4;

    typedef logic [PIX_W-1:0] pix_t;

    // Low half holds the even-column pixel.
    typedef struct packed {
        pix_t hi;
        pix_t lo;
    } fb_word_t;

    typedef enum logic {
        SLOT_WR,
        SLOT_DISP
    } slot_e;

endpackage

// File: rtl/vga_fb_pix_unpack.sv
// Captures the framebuffer read word and emits its two pixels aligned
// two cycles behind col/disp_ena.
module vga_fb_pix_unpack
    import vga_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     disp_ena_i,
    input  logic     col_odd_i,
    input  fb_word_t fb_rdata_i,
    output pix_t     pix_o,
    output logic     pix_valid_o
);

    logic     ena1_q, odd1_q, ena2_q, odd2_q;
    fb_word_t held_q, held_d;

    // Only a display read one cycle back loads the word, so writer traffic
    // on odd/blank slots never disturbs the pixel pair being shown.
    always_comb begin
        held_d = held_q;
        if (ena1_q && !odd1_q) begin
            held_d = fb_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ena1_q <= 1'b0;
            odd1_q <= 1'b0;
            ena2_q <= 1'b0;
            odd2_q <= 1'b0;
            held_q <= '0;
        end else begin
            ena1_q <= disp_ena_i;
            odd1_q <= col_odd_i;
            ena2_q <= ena1_q;
            odd2_q <= odd1_q;
            held_q <= held_d;
        end
    end

    always_comb begin
        pix_o = '0;
        if (ena2_q) begin
            pix_o = odd2_q ? held_q.hi : held_q.lo;
        end
    end

    assign pix_valid_o = ena2_q;

endmodule

// File: rtl/vga_fb_scheduler.sv
// Single-port framebuffer arbiter: display fetch on even active columns,
// writer on all other slots. Optional stats via VGA_FB_STATS_EN.
module vga_fb_scheduler
    import vga_pkg::*;
#(
    parameter int unsigned SIZE     = vga_pkg::SIZE,
    parameter int unsigned H_PIXELS = 50 * SIZE,
    parameter int unsigned V_PIXELS = 25 * SIZE,
    parameter int unsigned PIX_W    = vga_pkg::PIX_W,
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               disp_ena,
    input  logic [H_BITS-1:0]  col,
    input  logic [V_BITS-1:0]  row,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [2*PIX_W-1:0] wr_data,
    output logic               fb_en,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [2*PIX_W-1:0] fb_wdata,
    input  logic [2*PIX_W-1:0] fb_rdata,
    output logic [PIX_W-1:0]   pix_out,
    output logic               pix_valid,
    output logic               wr_starved
`ifdef VGA_FB_STATS_EN
   ,output logic [15:0]        stat_wr_cnt,
    output logic [4:0]         stat_max_wait
`endif
);

    localparam int unsigned FB_WORDS = V_PIXELS * H_PIXELS / 2;

    if ((2 ** ADDR_W) < FB_WORDS) begin : g_addr_w_check
        $error("ADDR_W too small for the framebuffer");
    end
    if (PIX_W != vga_pkg::PIX_W) begin : g_pix_w_check
        $error("PIX_W must match vga_pkg::PIX_W");
    end

    slot_e             slot;
    logic [ADDR_W-1:0] disp_addr;
    logic              xfer;
    logic [4:0]        wait_q, wait_d;
    logic              starved_q, starved_d;

    assign disp_addr = ADDR_W'(row) * ADDR_W'(H_PIXELS / 2) + ADDR_W'(col[H_BITS-1:1]);

    always_comb begin
        slot     = (disp_ena && !col[0]) ? SLOT_DISP : SLOT_WR;
        fb_en    = 1'b0;
        fb_we    = 1'b0;
        fb_addr  = disp_addr;
        fb_wdata = wr_data;
        wr_ready = 1'b0;
        if (!rst) begin
            case (slot)
                SLOT_DISP: fb_en = 1'b1;
                SLOT_WR: begin
                    wr_ready = wr_valid;
                    fb_en    = wr_valid;
                    fb_we    = wr_valid;
                    fb_addr  = wr_addr;
                end
                default: ;
            endcase
        end
    end

    assign xfer = wr_valid && wr_ready;

    always_comb begin
        wait_d = wait_q;
        if (xfer) begin
            wait_d = '0;
        end else if (wr_valid && !wait_q[4:0] == 1'b0 && wait_q != '1) begin
            wait_d = wait_q + 5'd1;
        end else if (wr_valid && wait_q == '0) begin
            wait_d = 5'd1;
        end
        starved_d = starved_q || (wait_q > 5'(MAX_WAIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q    <= '0;
            starved_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            starved_q <= starved_d;
        end
    end

    assign wr_starved = starved_q;

`ifdef VGA_FB_STATS_EN
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [4:0]  max_wait_q, max_wait_d;

    always_comb begin
        wr_cnt_d   = xfer ? wr_cnt_q + 16'd1 : wr_cnt_q;
        max_wait_d = (wait_q > max_wait_q) ? wait_q : max_wait_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q   <= '0;
            max_wait_q <= '0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            max_wait_q <= max_wait_d;
        end
    end

    assign stat_wr_cnt   = wr_cnt_q;
    assign stat_max_wait = max_wait_q;
`endif

    vga_fb_pix_unpack u_unpack (
        .clk         (clk),
        .rst         (rst),
        .disp_ena_i  (disp_ena),
        .col_odd_i   (col[0]),
        .fb_rdata_i  (fb_rdata),
        .pix_o       (pix_out),
        .pix_valid_o (pix_valid)
    );

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler: slot table plus pixel, starvation
// and reset sequences against a behavioural single-port RAM.
module tb_vga_fb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_ena;
    logic [7:0]  col;
    logic [6:0]  row;
    logic        wr_valid;
    logic        wr_ready;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        fb_en;
    logic        fb_we;
    logic [12:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic [7:0]  fb_rdata;
    logic [3:0]  pix_out;
    logic        pix_valid;
    logic        wr_starved;
`ifdef VGA_FB_STATS_EN
    logic [15:0] stat_wr_cnt;
    logic [4:0]  stat_max_wait;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:8191];

    always #5 clk = ~clk;

    // Write-first RAM: a write also drives rdata, exposing any stray capture.
    always @(posedge clk) begin
        if (fb_en) begin
            if (fb_we) begin
                mem[fb_addr] <= fb_wdata;
                fb_rdata     <= fb_wdata;
            end else begin
                fb_rdata <= mem[fb_addr];
            end
        end
    end

    vga_fb_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .disp_ena   (disp_ena),
        .col        (col),
        .row        (row),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .fb_en      (fb_en),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .fb_rdata   (fb_rdata),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .wr_starved (wr_starved)
`ifdef VGA_FB_STATS_EN
       ,.stat_wr_cnt   (stat_wr_cnt),
        .stat_max_wait (stat_max_wait)
`endif
    );

    typedef struct {
        logic        ena;
        logic [7:0]  col;
        logic [6:0]  row;
        logic        wv;
        logic [12:0] waddr;
        logic [7:0]  wdata;
        logic        en;
        logic        we;
        logic        rdy;
        logic [12:0] addr;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [7:0] c, input logic [6:0] r,
                         input logic v, input logic [12:0] a, input logic [7:0] d);
        disp_ena = e;
        col      = c;
        row      = r;
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    initial begin
        //          ena  col    row   wv    waddr    wdata   en    we    rdy   addr
        vt[0] = '{1'b0, 8'd0,   7'd0,  1'b1, 13'h010, 8'h3C, 1'b1, 1'b1, 1'b1, 13'h010};
        vt[1] = '{1'b1, 8'd10,  7'd2,  1'b0, 13'h000, 8'h00, 1'b1, 1'b0, 1'b0, 13'd155};
        vt[2] = '{1'b1, 8'd10,  7'd2,  1'b1, 13'h020, 8'h44, 1'b1, 1'b0, 1'b0, 13'd155};
        vt[3] = '{1'b1, 8'd11,  7'd2,  1'b1, 13'h020, 8'h44, 1'b1, 1'b1, 1'b1, 13'h020};
        vt[4] = '{1'b1, 8'd149, 7'd74, 1'b1, 13'h100, 8'h99, 1'b1, 1'b1, 1'b1, 13'h100};
        vt[5] = '{1'b1, 8'd148, 7'd74, 1'b0, 13'h000, 8'h00, 1'b1, 1'b0, 1'b0, 13'd5624};
        vt[6] = '{1'b1, 8'd0,   7'd0,  1'b0, 13'h000, 8'h00, 1'b1, 1'b0, 1'b0, 13'd0};
        vt[7] = '{1'b0, 8'd0,   7'd0,  1'b0, 13'h000, 8'h00, 1'b0, 1'b0, 1'b0, 13'd0};
        vt[8] = '{1'b1, 8'd1,   7'd0,  1'b0, 13'h000, 8'h00, 1'b0, 1'b0, 1'b0, 13'd0};

        // Reset: writer requesting during blanking must still be held off.
        rst = 1'b1;
        drive(1'b0, 8'd0, 7'd0, 1'b1, 13'h010, 8'h11);
        tick;
        settle;
        chk("rst_fb_en", fb_en, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_fb_we", fb_we, 0);
        tick;
        settle;
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_out", pix_out, 0);
        chk("rst_starved", wr_starved, 0);
        rst = 1'b0;

        // Preload pixel words through the writer during blanking.
        drive(1'b0, 8'd0, 7'd0, 1'b1, 13'd155, 8'hA5);
        settle;
        chk("blank_wr_ready", wr_ready, 1);
        tick;
        drive(1'b0, 8'd0, 7'd0, 1'b1, 13'd156, 8'h3C);
        tick;
        drive(1'b0, 8'd0, 7'd0, 1'b1, 13'd160, 8'h87);
        tick;
        drive(1'b0, 8'd0, 7'd0, 1'b1, 13'd0, 8'h21);
        tick;

        for (int i = 0; i < 9; i++) begin
            drive(vt[i].ena, vt[i].col, vt[i].row, vt[i].wv, vt[i].waddr, vt[i].wdata);
            settle;
            chk($sformatf("vec%0d_fb_en", i), fb_en, vt[i].en);
            chk($sformatf("vec%0d_fb_we", i), fb_we, vt[i].we);
            chk($sformatf("vec%0d_wr_ready", i), wr_ready, vt[i].rdy);
            if (vt[i].en) chk($sformatf("vec%0d_fb_addr", i), fb_addr, vt[i].addr);
            if (vt[i].we) chk($sformatf("vec%0d_fb_wdata", i), fb_wdata, vt[i].wdata);
            tick;
        end
        settle;
        chk("table_no_starve", wr_starved, 0);

        // Writer arriving on an even active column waits one slot.
        drive(1'b1, 8'd4, 7'd0, 1'b1, 13'h0AA, 8'h5A);
        settle;
        chk("col4_wr_ready", wr_ready, 0);
        chk("col4_fb_we", fb_we, 0);
        chk("col4_fb_addr", fb_addr, 2);
        tick;
        drive(1'b1, 8'd5, 7'd0, 1'b1, 13'h0AA, 8'h5A);
        settle;
        chk("col5_wr_ready", wr_ready, 1);
        chk("col5_fb_we", fb_we, 1);
        chk("col5_fb_addr", fb_addr, 13'h0AA);
        chk("col5_fb_wdata", fb_wdata, 8'h5A);
        tick;

        // Pixel pipeline, with a write landing on the odd slot in between.
        drive(1'b1, 8'd10, 7'd2, 1'b0, 13'h0, 8'h0);
        tick;
        drive(1'b1, 8'd11, 7'd2, 1'b1, 13'h500, 8'hFF);
        tick;
        drive(1'b1, 8'd12, 7'd2, 1'b0, 13'h0, 8'h0);
        settle;
        chk("pix_c10_lo", pix_out, 4'h5);
        chk("pix_c10_valid", pix_valid, 1);
        tick;
        drive(1'b1, 8'd13, 7'd2, 1'b0, 13'h0, 8'h0);
        settle;
        chk("pix_c11_hi", pix_out, 4'hA);
        chk("pix_c11_valid", pix_valid, 1);
        tick;
        drive(1'b0, 8'd14, 7'd2, 1'b0, 13'h0, 8'h0);
        settle;
        chk("pix_c12_lo", pix_out, 4'hC);
        tick;
        drive(1'b0, 8'd15, 7'd2, 1'b0, 13'h0, 8'h0);
        settle;
        chk("pix_c13_hi", pix_out, 4'h3);
        chk("pix_c13_valid", pix_valid, 1);
        tick;
        settle;
        chk("pix_blank_valid", pix_valid, 0);
        chk("pix_blank_out", pix_out, 0);

        // disp_ena drops after the even column; writer takes the odd slot.
        drive(1'b1, 8'd20, 7'd2, 1'b0, 13'h0, 8'h0);
        tick;
        drive(1'b0, 8'd21, 7'd2, 1'b1, 13'h600, 8'hEE);
        tick;
        drive(1'b0, 8'd22, 7'd2, 1'b0, 13'h0, 8'h0);
        settle;
        chk("fall_lo", pix_out, 4'h7);
        chk("fall_lo_valid", pix_valid, 1);
        tick;
        settle;
        chk("fall_hi_valid", pix_valid, 0);
        chk("fall_hi_out", pix_out, 0);

        // Starvation: 15 suppressed cycles is not enough, 16 is.
        drive(1'b0, 8'd0, 7'd0, 1'b1, 13'h700, 8'h01);
        tick;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 8'd2, 7'd0, 1'b1, 13'h700, 8'h01);
            tick;
        end
        drive(1'b1, 8'd3, 7'd0, 1'b1, 13'h700, 8'h01);
        settle;
        chk("wait15_grant", wr_ready, 1);
        tick;
        drive(1'b0, 8'd0, 7'd0, 1'b0, 13'h0, 8'h0);
        settle;
        chk("wait15_no_starve", wr_starved, 0);
        tick;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'd2, 7'd0, 1'b1, 13'h700, 8'h02);
            tick;
        end
        drive(1'b1, 8'd3, 7'd0, 1'b1, 13'h700, 8'h02);
        settle;
        chk("wait16_not_yet", wr_starved, 0);
        chk("wait16_grant", wr_ready, 1);
        tick;
        drive(1'b0, 8'd0, 7'd0, 1'b0, 13'h0, 8'h0);
        settle;
        chk("wait16_starved", wr_starved, 1);
        tick;
        tick;
        settle;
        chk("starved_sticky", wr_starved, 1);

        // Reset in the middle of an active line, then replay.
        drive(1'b1, 8'd72, 7'd3, 1'b1, 13'h7F0, 8'h00);
        tick;
        rst = 1'b1;
        drive(1'b1, 8'd73, 7'd3, 1'b1, 13'h7F0, 8'h00);
        settle;
        chk("midrst_fb_en", fb_en, 0);
        chk("midrst_wr_ready", wr_ready, 0);
        tick;
        rst = 1'b0;
        drive(1'b1, 8'd74, 7'd3, 1'b0, 13'h0, 8'h0);
        settle;
        chk("midrst_pix_valid", pix_valid, 0);
        chk("midrst_starved_clr", wr_starved, 0);
        tick;
        drive(1'b1, 8'd0, 7'd0, 1'b0, 13'h0, 8'h0);
        settle;
        chk("midrst_pix_valid2", pix_valid, 0);
        tick;
        drive(1'b1, 8'd1, 7'd0, 1'b0, 13'h0, 8'h0);
        tick;
        drive(1'b1, 8'd2, 7'd0, 1'b0, 13'h0, 8'h0);
        settle;
        chk("replay_lo", pix_out, 4'h1);
        chk("replay_lo_valid", pix_valid, 1);
        tick;
        drive(1'b0, 8'd0, 7'd0, 1'b0, 13'h0, 8'h0);
        settle;
        chk("replay_hi", pix_out, 4'h2);
        chk("replay_hi_valid", pix_valid, 1);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
